vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing and test-pattern generator, the successor to the fixed 640x480 sync driver in the top level.
- Sits between the PLL clock domain and the video output pins.
- All H/V timings, sync polarities and colour width are parameters.
- Uses a pixel clock-enable in place of a divided clock.
- Adds selectable pattern modes, frame-synchronous mode switching, active-area coordinates and line/frame strobes.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of HSYNC (0 = active low)
- VSYNC_POL, 0, asserted level of VSYNC
- COLOR_BITS, 3, width of the pixel data path
- CNT_W, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- CLK  in  1  system clock (50 MHz)
- RST  in  1  asynchronous, active-high reset
- PIX_EN  in  1  pixel clock enable; one pixel advance per CLK cycle with PIX_EN=1
- MODE  in  2  pattern select: 0 XOR checker, 1 colour bars, 2 solid white, 3 external
- PAT_IN  in  COLOR_BITS  external pixel data, used in MODE 3
- HSYNC  out  1  horizontal sync, registered
- VSYNC  out  1  vertical sync, registered
- ACTIVE  out  1  visible-area flag, registered
- RGB  out  COLOR_BITS  pixel data, forced to 0 outside the active area
- HCOUNT  out  CNT_W  x coordinate within the active area (0 when blanked)
- VCOUNT  out  CNT_W  y coordinate within the active area (0 when blanked)
- LINE_START  out  1  one-CLK strobe at h=0
- FRAME_START  out  1  one-CLK strobe at h=0, v=0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL likewise (default 525).
- Line order: active, front porch, sync, back porch. Frame order is the same.
- Internal counters hc and vc; all state advances only on CLK edges with PIX_EN=1.
- hc wraps from H_TOTAL-1 to 0. vc increments only on that wrap and wraps from V_TOTAL-1 to 0.
- Each enabled edge registers all outputs from the current (hc, vc), then advances the counters. The output after the k-th enabled edge therefore reflects h=k-1. Fixed latency is 1 enabled cycle; all outputs are mutually aligned.
- ACTIVE = (hc < H_ACTIVE) && (vc < V_ACTIVE).
- HSYNC = HSYNC_POL when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, else ~HSYNC_POL. VSYNC is the same on vc.
- HCOUNT/VCOUNT = hc/vc when ACTIVE, else 0.
- Pattern, computed from hc/vc:
  - MODE 0: {x[2:0]^y[2:0]}, zero-extended or truncated to COLOR_BITS.
  - MODE 1: 8 vertical bars, each H_ACTIVE/8 pixels wide, with values 0..7 (truncated to COLOR_BITS). Bar index comes from a sequential sub-counter cleared at hc=0, not from a divider.
  - MODE 2: all ones.
  - MODE 3: PAT_IN as sampled on the same enabled edge.
- Mode switching: MODE is latched into an internal register only on the enabled edge where hc=0 and vc=0. A mid-frame MODE change takes effect at the next frame; no tearing.
- Strobes: LINE_START is high for exactly one CLK cycle, the cycle following an enabled edge at hc=0. FRAME_START additionally requires vc=0. Outputs other than the strobes hold their values between enabled edges.
- PIX_EN=0 indefinitely: everything freezes; strobes stay 0.
- Reset, asynchronous and at any time including mid-line:
  - hc=vc=0, latched mode=0.
  - HSYNC=~HSYNC_POL, VSYNC=~VSYNC_POL.
  - ACTIVE=0, RGB=0, HCOUNT=VCOUNT=0, LINE_START=FRAME_START=0.
  - The first enabled edge after release produces h=0, v=0, with FRAME_START and LINE_START pulsed.

Test Plan:
- Reset, PIX_EN tied 1, defaults:
  - FRAME_START strobe after edge 1, with ACTIVE=1 and RGB=0.
  - LINE_START every 800 cycles; FRAME_START every 420000 cycles.
- Sync timing:
  - HSYNC low for exactly 96 cycles, outputs after edges 657..752, high otherwise.
  - VSYNC low for lines 490..491 only.
  - With HSYNC_POL=1, the same windows appear high.
- Blanking:
  - At h=640..799 or v=480..524: ACTIVE=0, RGB=0, HCOUNT=VCOUNT=0.
  - At (639,479): ACTIVE=1, HCOUNT=639, VCOUNT=479.
- Patterns:
  - MODE 0 at (5,3) gives RGB=6.
  - MODE 1 at x=0/80/639 gives RGB=0/1/7.
  - MODE 2 gives 7 everywhere active.
  - MODE 3 with PAT_IN=5 gives 5.
- Frame-synchronous mode:
  - Change MODE 0 to 2 at v=100; rest of the frame stays XOR.
  - Solid white starts at the next FRAME_START.
- PIX_EN=1 every other cycle: all periods double in CLK cycles; strobes remain 1 CLK wide. Assert RST mid-line at h=300: outputs go to reset values immediately, and the restart begins at h=0, v=0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// ============================================================================
// vga_timing_gen : parametrised VGA raster timing and test-pattern generator
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int COLOR_BITS = 3,
  parameter int CNT_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pix_en,
  input  logic [1:0]            i_mode,
  input  logic [COLOR_BITS-1:0] i_pat_in,
  output logic                  o_hsync,
  output logic                  o_vsync,
  output logic                  o_active,
  output logic [COLOR_BITS-1:0] o_rgb,
  output logic [CNT_W-1:0]      o_hcount,
  output logic [CNT_W-1:0]      o_vcount,
  output logic                  o_line_start,
  output logic                  o_frame_start
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam int c_PW      = (COLOR_BITS > 3) ? COLOR_BITS : 3;

  localparam logic [CNT_W-1:0] c_H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] c_H_SYNC_S = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] c_H_SYNC_E = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] c_H_LAST   = CNT_W'(c_H_TOTAL - 1);
  localparam logic [CNT_W-1:0] c_V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] c_V_SYNC_S = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] c_V_SYNC_E = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] c_V_LAST   = CNT_W'(c_V_TOTAL - 1);
  localparam logic [CNT_W-1:0] c_BAR_LAST = CNT_W'(c_BAR_W - 1);

  localparam logic [1:0] c_MODE_XOR   = 2'd0;
  localparam logic [1:0] c_MODE_BARS  = 2'd1;
  localparam logic [1:0] c_MODE_WHITE = 2'd2;

  logic [CNT_W-1:0]      r_hc;
  logic [CNT_W-1:0]      r_vc;
  logic [CNT_W-1:0]      r_bar_cnt;
  logic [2:0]            r_bar_idx;
  logic [1:0]            r_mode;

  logic                  w_h_last;
  logic                  w_v_last;
  logic                  w_origin;
  logic                  w_active;
  logic                  w_hs;
  logic                  w_vs;
  logic [1:0]            w_mode;
  logic [2:0]            w_pat3;
  logic [c_PW-1:0]       w_pat3_ext;
  logic [COLOR_BITS-1:0] w_pat;

  always_comb begin
    w_h_last = (r_hc == c_H_LAST);
    w_v_last = (r_vc == c_V_LAST);
    w_origin = (r_hc == '0) && (r_vc == '0);
    w_active = (r_hc < c_H_ACT) && (r_vc < c_V_ACT);
    w_hs     = ((r_hc >= c_H_SYNC_S) && (r_hc < c_H_SYNC_E)) ? HSYNC_POL : ~HSYNC_POL;
    w_vs     = ((r_vc >= c_V_SYNC_S) && (r_vc < c_V_SYNC_E)) ? VSYNC_POL : ~VSYNC_POL;
    // The frame origin pixel already belongs to the new frame, so it uses the incoming mode.
    w_mode   = w_origin ? i_mode : r_mode;
    w_pat3   = (w_mode == c_MODE_BARS) ? r_bar_idx : (r_hc[2:0] ^ r_vc[2:0]);
    w_pat3_ext = c_PW'(w_pat3);
    case (w_mode)
      c_MODE_XOR,
      c_MODE_BARS:  w_pat = w_pat3_ext[COLOR_BITS-1:0];
      c_MODE_WHITE: w_pat = '1;
      default:      w_pat = i_pat_in;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hc          <= '0;
      r_vc          <= '0;
      r_bar_cnt     <= '0;
      r_bar_idx     <= '0;
      r_mode        <= c_MODE_XOR;
      o_hsync       <= ~HSYNC_POL;
      o_vsync       <= ~VSYNC_POL;
      o_active      <= 1'b0;
      o_rgb         <= '0;
      o_hcount      <= '0;
      o_vcount      <= '0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      if (i_pix_en) begin
        o_hsync       <= w_hs;
        o_vsync       <= w_vs;
        o_active      <= w_active;
        o_rgb         <= w_active ? w_pat : '0;
        o_hcount      <= w_active ? r_hc : '0;
        o_vcount      <= w_active ? r_vc : '0;
        o_line_start  <= (r_hc == '0);
        o_frame_start <= w_origin;

        if (w_origin) begin
          r_mode <= i_mode;
        end

        if (w_h_last) begin
          r_hc <= '0;
          r_vc <= w_v_last ? '0 : r_vc + 1'b1;
        end else begin
          r_hc <= r_hc + 1'b1;
        end

        // Bar index tracks hc without a divider; it saturates on the last bar.
        if (w_h_last) begin
          r_bar_cnt <= '0;
          r_bar_idx <= '0;
        end else if (r_bar_cnt == c_BAR_LAST) begin
          r_bar_cnt <= '0;
          if (r_bar_idx != 3'd7) begin
            r_bar_idx <= r_bar_idx + 1'b1;
          end
        end else begin
          r_bar_cnt <= r_bar_cnt + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// tb_vga_timing_gen : directed self-checking bench for vga_timing_gen
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

  localparam int HA = 16;
  localparam int HT = 24;
  localparam int VT = 12;
  localparam int FR = HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [2:0] pat_in = 3'd0;

  logic       hs, vs, act, ls, fs;
  logic [2:0] rgb;
  logic [9:0] hco, vco;
  logic       hs_p, vs_p, act_p, ls_p, fs_p;
  logic [2:0] rgb_p;
  logic [9:0] hco_p, vco_p;

  int n_vec = 0;
  int n_err = 0;
  int p = -1;
  int h = 0;
  int v = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COLOR_BITS(3), .CNT_W(10)
  ) u_dut (
    .clk(clk), .rst(rst), .i_pix_en(pix_en), .i_mode(mode), .i_pat_in(pat_in),
    .o_hsync(hs), .o_vsync(vs), .o_active(act), .o_rgb(rgb),
    .o_hcount(hco), .o_vcount(vco), .o_line_start(ls), .o_frame_start(fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COLOR_BITS(3), .CNT_W(10)
  ) u_dut_pos (
    .clk(clk), .rst(rst), .i_pix_en(pix_en), .i_mode(mode), .i_pat_in(pat_in),
    .o_hsync(hs_p), .o_vsync(vs_p), .o_active(act_p), .o_rgb(rgb_p),
    .o_hcount(hco_p), .o_vcount(vco_p), .o_line_start(ls_p), .o_frame_start(fs_p)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    p = (p + 1) % FR;
    h = p % HT;
    v = p / HT;
  endtask

  task automatic seek(input int th, input int tv);
    int n;
    n = 0;
    while (!(h == th && v == tv) && n < FR) begin
      tick();
      n++;
    end
    chk("seek", (h == th && v == tv) ? 1 : 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int first_ls, first_fs, n_ls, n_fs, n_hl, n_vl, n_act, n_pol, n_blank;
    int n_lse, n_fse, n_cnte, n_ls2, ls_gap, n_hl2, n_strb, n_frz;
    first_ls = 0; first_fs = 0; n_ls = 0; n_fs = 0; n_hl = 0; n_vl = 0;
    n_act = 0; n_pol = 0; n_blank = 0;
    n_lse = 0; n_fse = 0; n_cnte = 0; n_ls2 = 0; ls_gap = 0; n_hl2 = 0;
    n_strb = 0; n_frz = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_hsync", hs, 1);
    chk("rst_vsync", vs, 1);
    chk("rst_active", act, 0);
    chk("rst_rgb", rgb, 0);
    chk("rst_hcount", hco, 0);
    chk("rst_vcount", vco, 0);
    chk("rst_line_start", ls, 0);
    chk("rst_frame_start", fs, 0);
    chk("rst_hsync_pos", hs_p, 0);
    chk("rst_vsync_pos", vs_p, 0);

    @(negedge clk);
    rst = 1'b0;
    pix_en = 1'b1;
    tick();
    chk("edge1_fs", fs, 1);
    chk("edge1_ls", ls, 1);
    chk("edge1_active", act, 1);
    chk("edge1_rgb", rgb, 0);
    chk("edge1_hcount", hco, 0);

    // One full frame of pixels 1..287 then pixel 0 of the next frame.
    for (int i = 1; i <= FR; i++) begin
      tick();
      if (ls) begin n_ls++; if (first_ls == 0) first_ls = i; end
      if (fs) begin n_fs++; if (first_fs == 0) first_fs = i; end
      if (!hs) n_hl++;
      if (!vs) n_vl++;
      if (act) n_act++;
      if (hs_p === hs || vs_p === vs) n_pol++;
      if (!act && (rgb != 3'd0 || hco != 10'd0 || vco != 10'd0)) n_blank++;
      if (h == 5 && v == 3) chk("xor_5_3", rgb, 6);
      if (h == 15 && v == 7) begin
        chk("corner_active", act, 1);
        chk("corner_hcount", hco, 15);
        chk("corner_vcount", vco, 7);
      end
      if (h == 16 && v == 7) chk("hblank_active", act, 0);
      if (h == 15 && v == 8) chk("vblank_active", act, 0);
      if (v == 0 && h >= 17 && h <= 21) chk("hsync_edge", hs, (h >= 18 && h <= 20) ? 0 : 1);
      if (h == 0 && v >= 8 && v <= 11) chk("vsync_line", vs, (v == 9 || v == 10) ? 0 : 1);
      if (h == 18 && v == 0) chk("hsync_pos_high", hs_p, 1);
    end
    chk("line_period", first_ls, 24);
    chk("frame_period", first_fs, 288);
    chk("line_strobes", n_ls, 12);
    chk("frame_strobes", n_fs, 1);
    chk("hsync_low_cycles", n_hl, 36);
    chk("vsync_low_cycles", n_vl, 48);
    chk("active_cycles", n_act, 128);
    chk("polarity_inverse", n_pol, 0);
    chk("blank_zeroed", n_blank, 0);

    seek(0, 4);
    mode = 2'd2;
    seek(3, 6);
    chk("no_tear_xor", rgb, 5);
    seek(0, 0);
    chk("white_fs", fs, 1);
    chk("white_0_0", rgb, 7);
    tick();
    chk("white_1_0", rgb, 7);
    seek(5, 3);
    chk("white_5_3", rgb, 7);
    seek(16, 3);
    chk("white_blank", rgb, 0);
    seek(15, 7);
    chk("white_15_7", rgb, 7);

    seek(0, 4);
    mode = 2'd1;
    seek(2, 5);
    chk("no_tear_white", rgb, 7);
    seek(0, 0);
    chk("bars_0_0", rgb, 0);
    seek(0, 2);
    chk("bars_x0", rgb, 0);
    tick();
    chk("bars_x1", rgb, 0);
    tick();
    chk("bars_x2", rgb, 1);
    seek(6, 2);
    chk("bars_x6", rgb, 3);
    seek(14, 2);
    chk("bars_x14", rgb, 7);
    tick();
    chk("bars_x15", rgb, 7);

    seek(0, 4);
    mode = 2'd3;
    pat_in = 3'd5;
    seek(4, 5);
    chk("no_tear_bars", rgb, 2);
    seek(0, 0);
    seek(4, 2);
    chk("ext_pat5", rgb, 5);
    pat_in = 3'd2;
    tick();
    chk("ext_pat2", rgb, 2);
    pat_in = 3'd5;
    seek(16, 2);
    chk("ext_blank", rgb, 0);

    seek(10, 3);
    chk("pre_rst_active", act, 1);
    chk("pre_rst_hcount", hco, 10);
    chk("pre_rst_rgb", rgb, 5);
    rst = 1'b1;
    #2;
    chk("async_rst_active", act, 0);
    chk("async_rst_hcount", hco, 0);
    chk("async_rst_vcount", vco, 0);
    chk("async_rst_rgb", rgb, 0);
    chk("async_rst_hsync", hs, 1);
    chk("async_rst_vsync", vs, 1);
    chk("async_rst_hsync_pos", hs_p, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    mode = 2'd0;
    rst = 1'b0;
    pix_en = 1'b1;

    // Enable on odd cycles only: pixel index after cycle c is (c+1)/2 - 1.
    for (int c = 1; c <= 90; c++) begin
      int q, qh, qv, eh, ev;
      @(posedge clk);
      #1;
      q  = (c + 1) / 2 - 1;
      qh = q % HT;
      qv = q / HT;
      eh = (qh < HA) ? qh : 0;
      ev = (qh < HA) ? qv : 0;
      if (ls !== ((c % 2 == 1) && qh == 0)) n_lse++;
      if (fs !== (c == 1)) n_fse++;
      if (int'(hco) != eh || int'(vco) != ev) n_cnte++;
      if (ls) begin
        n_ls2++;
        if (c > 1 && ls_gap == 0) ls_gap = c - 1;
      end
      if (!hs) n_hl2++;
      if (c == 1) begin
        chk("restart_fs", fs, 1);
        chk("restart_active", act, 1);
        chk("restart_hcount", hco, 0);
      end
      pix_en = (c % 2 == 0);
    end
    chk("half_ls_pattern", n_lse, 0);
    chk("half_fs_pattern", n_fse, 0);
    chk("half_coords", n_cnte, 0);
    chk("half_ls_count", n_ls2, 2);
    chk("half_line_period", ls_gap, 48);
    chk("half_hsync_low", n_hl2, 12);

    pix_en = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (ls || fs) n_strb++;
      if (hs !== 1'b0 || act !== 1'b0 || hco !== 10'd0) n_frz++;
    end
    chk("freeze_strobes", n_strb, 0);
    chk("freeze_hold", n_frz, 0);
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    chk("unfreeze_hsync", hs, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
